// File: rtl/bit_frame_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bit_frame_counter
//  Brief    : Down-counting frame timer with one-shot/continuous reload,
//             graceful stop, abort, completed-frame count and start error flag.
//  Revision : 1.0  initial release
// ============================================================================
module bit_frame_counter #(
    parameter int WIDTH   = 4,
    parameter int FRAME_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [WIDTH-1:0]   max_count,
    input  logic               enable,
    input  logic               stop,
    input  logic               abort,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               tc,
    output logic [FRAME_W-1:0] frames,
    output logic               start_err
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_count;
    logic               r_mode;
    logic               r_stop_pend;
    logic [FRAME_W-1:0] r_frames;
    logic               r_start_err;
    logic               w_tc;

    assign w_tc = (r_state == c_RUN) && enable && (r_count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_count     <= '0;
            r_mode      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_frames    <= '0;
            r_start_err <= 1'b0;
        end else if (abort) begin
            // Abort overrides everything, including a same-cycle terminal count.
            r_state     <= c_IDLE;
            r_count     <= '0;
            r_stop_pend <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state     <= c_RUN;
                        r_count     <= max_count;
                        r_mode      <= mode;
                        r_stop_pend <= 1'b0;
                    end
                end
                default: begin
                    if (start) begin
                        r_start_err <= 1'b1;
                    end
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_tc) begin
                        r_frames <= r_frames + 1'b1;
                        if (!r_mode || r_stop_pend || stop) begin
                            r_state     <= c_IDLE;
                            r_count     <= '0;
                            r_stop_pend <= 1'b0;
                        end else begin
                            r_count <= max_count;
                        end
                    end else if (enable) begin
                        r_count <= r_count - 1'b1;
                    end
                end
            endcase
        end
    end

    assign count     = r_count;
    assign busy      = (r_state == c_RUN);
    assign tc        = w_tc;
    assign frames    = r_frames;
    assign start_err = r_start_err;

endmodule
`default_nettype wire

// File: tb/tb_bit_frame_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_frame_counter
//  Brief    : Self-checking bench; a slot-accounting model predicts every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bit_frame_counter;

    localparam int WIDTH   = 4;
    localparam int FRAME_W = 8;
    localparam int VW      = WIDTH + FRAME_W + 3;

    logic               clk;
    logic               reset;
    logic               start, mode, enable, stop, abort;
    logic [WIDTH-1:0]   max_count;
    logic [WIDTH-1:0]   count;
    logic               busy, tc, start_err;
    logic [FRAME_W-1:0] frames;

    int n_cmp  = 0;
    int n_fail = 0;

    bit_frame_counter #(.WIDTH(WIDTH), .FRAME_W(FRAME_W)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .max_count(max_count), .enable(enable), .stop(stop), .abort(abort),
        .count(count), .busy(busy), .tc(tc), .frames(frames), .start_err(start_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a frame is m_len slots long, m_used of them already consumed.
    bit m_busy, m_mode, m_stop, m_err, m_last;
    int m_len, m_used, m_frames;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_mode = 0; m_stop = 0; m_err = 0;
            m_len = 1; m_used = 0; m_frames = 0;
        end else begin
            m_last = m_busy && enable && (m_used == m_len - 1);
            if (abort) begin
                m_busy = 0; m_err = 0; m_stop = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_mode = mode; m_stop = 0;
                    m_len = int'(max_count) + 1; m_used = 0;
                end
            end else begin
                if (start) m_err = 1;
                if (m_last) begin
                    m_frames = (m_frames + 1) % (1 << FRAME_W);
                    if (!m_mode || m_stop || stop) m_busy = 0;
                    else begin m_len = int'(max_count) + 1; m_used = 0; end
                end else begin
                    if (stop) m_stop = 1;
                    if (enable) m_used++;
                end
            end
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        logic [WIDTH-1:0] c;
        logic t;
        c = m_busy ? WIDTH'(m_len - 1 - m_used) : '0;
        t = m_busy && enable && (m_used == m_len - 1);
        return {c, m_busy, t, FRAME_W'(m_frames), m_err};
    endfunction

    task automatic set_in(input logic st, md, input logic [WIDTH-1:0] mc,
                          input logic en, sp, ab);
        start = st; mode = md; max_count = mc; enable = en; stop = sp; abort = ab;
    endtask

    task automatic advance();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, '0, 0, 0, 0);
        reset = 1'b1;
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_in(0, 0, '0, 0, 0, 0);
        reset = 1'b1;
        #2;
        n_cmp++;
        if ({count, busy, tc, frames, start_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", {count, busy, tc, frames, start_err});
        end
        advance();
        reset = 1'b0;
    endtask

    task automatic test_oneshot();
        int tc_at = -1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_in(i == 0, 0, 4'd3, 1, 0, 0);
            @(negedge clk);
            if (tc === 1'b1 && tc_at < 0) tc_at = i;
            n_cmp++;
            if ({count, busy, tc, frames, start_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL oneshot[%0d]: got %h expected %h", i, {count, busy, tc, frames, start_err}, exp_vec());
            end
            advance();
        end
        n_cmp++;
        if (tc_at != 4 || frames !== 8'd1) begin
            n_fail++;
            $display("FAIL oneshot_tc_cycle: got tc@%0d frames=%0d expected tc@4 frames=1", tc_at, frames);
        end
    endtask

    task automatic test_continuous();
        int tc_a = -1, tc_b = -1;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_in(i == 0, 1, (i < 2) ? 4'd2 : 4'd5, 1, i == 6, 0);
            @(negedge clk);
            if (tc === 1'b1) begin
                if (tc_a < 0) tc_a = i; else if (tc_b < 0) tc_b = i;
            end
            n_cmp++;
            if ({count, busy, tc, frames, start_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL continuous[%0d]: got %h expected %h", i, {count, busy, tc, frames, start_err}, exp_vec());
            end
            advance();
        end
        n_cmp++;
        if (tc_a != 3 || tc_b != 9 || frames !== 8'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL continuous_frames: got tc@%0d,%0d frames=%0d busy=%b expected tc@3,9 frames=2 busy=0",
                     tc_a, tc_b, frames, busy);
        end
    endtask

    task automatic test_stall();
        int tc_at = -1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_in(i == 0, 0, 4'd4, !(i >= 2 && i <= 4), 0, 0);
            @(negedge clk);
            if (tc === 1'b1 && tc_at < 0) tc_at = i;
            n_cmp++;
            if ({count, busy, tc, frames, start_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL stall[%0d]: got %h expected %h", i, {count, busy, tc, frames, start_err}, exp_vec());
            end
            advance();
        end
        n_cmp++;
        if (tc_at != 8) begin
            n_fail++;
            $display("FAIL stall_tc_cycle: got %0d expected 8", tc_at);
        end
    endtask

    task automatic test_abort();
        do_reset();
        // start while busy at i=2, abort on the terminal cycle i=3, start+abort in IDLE at i=5
        for (int i = 0; i < 8; i++) begin
            set_in(i == 0 || i == 2 || i == 5, 0, 4'd2, 1, 0, i == 3 || i == 5);
            @(negedge clk);
            n_cmp++;
            if ({count, busy, tc, frames, start_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL abort[%0d]: got %h expected %h", i, {count, busy, tc, frames, start_err}, exp_vec());
            end
            if (i == 3) begin
                n_cmp++;
                if (start_err !== 1'b1 || tc !== 1'b1) begin
                    n_fail++;
                    $display("FAIL abort_err_set: got err=%b tc=%b expected err=1 tc=1", start_err, tc);
                end
            end
            if (i == 4 || i == 6) begin
                n_cmp++;
                if ({count, busy, frames, start_err} !== '0) begin
                    n_fail++;
                    $display("FAIL abort_idle[%0d]: got %h expected 0", i, {count, busy, frames, start_err});
                end
            end
            advance();
        end
    endtask

    task automatic test_boundaries();
        int n_tc = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(i == 0, 1, 4'd0, 1, i == 5, 0);
            @(negedge clk);
            if (i >= 1 && i <= 5 && tc === 1'b1) n_tc++;
            n_cmp++;
            if ({count, busy, tc, frames, start_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL bound_mc0[%0d]: got %h expected %h", i, {count, busy, tc, frames, start_err}, exp_vec());
            end
            advance();
        end
        n_cmp++;
        if (n_tc != 5) begin
            n_fail++;
            $display("FAIL bound_mc0_tc: got %0d tc cycles expected 5", n_tc);
        end
        do_reset();
        for (int i = 0; i < 19; i++) begin
            set_in(i == 0, 0, 4'd15, 1, 0, 0);
            @(negedge clk);
            n_cmp++;
            if ({count, busy, tc, frames, start_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL bound_mc15[%0d]: got %h expected %h", i, {count, busy, tc, frames, start_err}, exp_vec());
            end
            if (i == 16) begin
                n_cmp++;
                if (tc !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bound_mc15_tc: got tc=%b at cycle 16 expected 1", tc);
                end
            end
            advance();
        end
        do_reset();
        for (int i = 0; i < 512; i++) begin
            set_in(i % 2 == 0, 0, 4'd0, 1, 0, 0);
            @(negedge clk);
            n_cmp++;
            if ({count, busy, tc, frames, start_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL bound_wrap[%0d]: got %h expected %h", i, {count, busy, tc, frames, start_err}, exp_vec());
            end
            advance();
        end
        set_in(0, 0, '0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (frames !== 8'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bound_wrap_final: got frames=%0d busy=%b expected 0 0", frames, busy);
        end
        advance();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(i == 0, 0, 4'd9, 1, 0, 0);
            advance();
        end
        set_in(1, 0, 4'd9, 1, 0, 0);   // also sets start_err at the next edge
        advance();
        set_in(0, 0, 4'd9, 1, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({count, busy, tc, frames, start_err} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0", {count, busy, tc, frames, start_err});
        end
        advance();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_in(i == 1, 0, 4'd2, 1, 0, 0);
            @(negedge clk);
            n_cmp++;
            if ({count, busy, tc, frames, start_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL async_after[%0d]: got %h expected %h", i, {count, busy, tc, frames, start_err}, exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                   ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 15)) : WIDTH'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
            @(negedge clk);
            n_cmp++;
            if ({count, busy, tc, frames, start_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, {count, busy, tc, frames, start_err}, exp_vec());
            end
            advance();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        set_in(0, 0, '0, 0, 0, 0);
        reset = 1'b0;
        #1;
        test_reset();
        test_oneshot();
        test_continuous();
        test_stall();
        test_abort();
        test_boundaries();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
